// File: rtl/jtag_tap_ctrl.sv
// rtl/jtag_tap_ctrl.sv - IEEE 1149.1 TAP controller: state machine, IR, decode, TDO mux.
// Define TAP_IDCODE_EN to add the 32-bit IDCODE register (opcode all-ones minus one).
module jtag_tap_ctrl #(
  parameter int          IR_WIDTH     = 4,
  parameter int          NUM_TDR      = 4,
  parameter logic [31:0] IDCODE_VALUE = 32'h0000_0001
) (
  input  logic                TCLK,
  input  logic                TRESETN,
  input  logic                TMS,
  input  logic                TDI,
  output logic                TDO,
  output logic                TDO_EN,
  output logic                CaptureDR,
  output logic                ShiftDR,
  output logic                UpdateDR,
  output logic [NUM_TDR-1:0]  TDR_EN,
  input  logic [NUM_TDR-1:0]  TDR_SO,
  output logic [IR_WIDTH-1:0] IR
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAUSE_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR
  } state_t;

  localparam logic [IR_WIDTH-1:0] OP_BYPASS  = '1;
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(1);
`ifdef TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] OP_IDCODE   = OP_BYPASS - IR_WIDTH'(1);
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = OP_IDCODE;
`else
  localparam logic [IR_WIDTH-1:0] RESET_INSTR = OP_BYPASS;
`endif

  state_t                state_q, state_d;
  logic [IR_WIDTH-1:0]   ir_shift_q, ir_shift_d;
  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic                  bypass_q, bypass_d;
  logic                  tdo_q, tdo_d;
  logic                  tdo_en_q, tdo_en_d;
  logic [NUM_TDR-1:0]    tdr_en;
  logic                  sel_idcode;
  logic                  idcode_so;

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) state_q <= TLR;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:      state_d = TMS ? TLR    : RTI;
      RTI:      state_d = TMS ? SEL_DR : RTI;
      SEL_DR:   state_d = TMS ? SEL_IR : CAP_DR;
      CAP_DR:   state_d = TMS ? EX1_DR : SH_DR;
      SH_DR:    state_d = TMS ? EX1_DR : SH_DR;
      EX1_DR:   state_d = TMS ? UPD_DR : PAUSE_DR;
      PAUSE_DR: state_d = TMS ? EX2_DR : PAUSE_DR;
      EX2_DR:   state_d = TMS ? UPD_DR : SH_DR;
      UPD_DR:   state_d = TMS ? SEL_DR : RTI;
      SEL_IR:   state_d = TMS ? TLR    : CAP_IR;
      CAP_IR:   state_d = TMS ? EX1_IR : SH_IR;
      SH_IR:    state_d = TMS ? EX1_IR : SH_IR;
      EX1_IR:   state_d = TMS ? UPD_IR : PAUSE_IR;
      PAUSE_IR: state_d = TMS ? EX2_IR : PAUSE_IR;
      EX2_IR:   state_d = TMS ? UPD_IR : SH_IR;
      UPD_IR:   state_d = TMS ? SEL_DR : RTI;
      default:  state_d = TLR;
    endcase
  end

  // Opcodes below NUM_TDR select a TDR; everything else leaves TDR_EN clear.
  always_comb begin
    tdr_en = '0;
    for (int k = 0; k < NUM_TDR; k++) tdr_en[k] = (ir_q == IR_WIDTH'(k));
  end

`ifdef TAP_IDCODE_EN
  logic [31:0] idcode_q, idcode_d;

  assign sel_idcode = (ir_q == OP_IDCODE);
  assign idcode_so  = idcode_q[0];

  always_comb begin
    idcode_d = idcode_q;
    if (state_q == CAP_DR)                  idcode_d = IDCODE_VALUE;
    else if (state_q == SH_DR && sel_idcode) idcode_d = {TDI, idcode_q[31:1]};
  end

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) idcode_q <= IDCODE_VALUE;
    else          idcode_q <= idcode_d;
  end
`else
  logic unused_idcode;

  assign sel_idcode    = 1'b0;
  assign idcode_so     = 1'b0;
  assign unused_idcode = ^IDCODE_VALUE;
`endif

  always_comb begin
    ir_shift_d = ir_shift_q;
    bypass_d   = bypass_q;
    if (state_q == CAP_IR)     ir_shift_d = IR_CAPTURE;
    else if (state_q == SH_IR) ir_shift_d = {TDI, ir_shift_q[IR_WIDTH-1:1]};
    if (state_q == CAP_DR)     bypass_d = 1'b0;
    else if (state_q == SH_DR && !(|tdr_en) && !sel_idcode) bypass_d = TDI;
  end

  always_ff @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) begin
      ir_shift_q <= '0;
      bypass_q   <= 1'b0;
    end else begin
      ir_shift_q <= ir_shift_d;
      bypass_q   <= bypass_d;
    end
  end

  // Falling-edge side: instruction update and TDO retiming.
  always_comb begin
    ir_d     = ir_q;
    tdo_d    = 1'b0;
    tdo_en_d = 1'b0;
    if (state_q == TLR)         ir_d = RESET_INSTR;
    else if (state_q == UPD_IR) ir_d = ir_shift_q;
    if (state_q == SH_IR) begin
      tdo_d    = ir_shift_q[0];
      tdo_en_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_en_d = 1'b1;
      if (|tdr_en)         tdo_d = |(TDR_SO & tdr_en);
      else if (sel_idcode) tdo_d = idcode_so;
      else                 tdo_d = bypass_q;
    end
  end

  always_ff @(negedge TCLK or negedge TRESETN) begin
    if (!TRESETN) begin
      ir_q     <= RESET_INSTR;
      tdo_q    <= 1'b0;
      tdo_en_q <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      tdo_q    <= tdo_d;
      tdo_en_q <= tdo_en_d;
    end
  end

  assign CaptureDR = (state_q == CAP_DR);
  assign ShiftDR   = (state_q == SH_DR);
  assign UpdateDR  = (state_q == UPD_DR);
  assign TDR_EN    = tdr_en;
  assign IR        = ir_q;
  assign TDO       = tdo_q;
  assign TDO_EN    = tdo_en_q;

endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb/tb_jtag_tap_ctrl.sv - self-checking bench for jtag_tap_ctrl
`timescale 1ns/1ps
module tb_jtag_tap_ctrl;
  localparam int          IRW = 4;
  localparam int          NT  = 4;
  localparam logic [31:0] IDV = 32'h1234_5679;
`ifdef TAP_IDCODE_EN
  localparam logic [IRW-1:0] RST_IR = 4'hE;
`else
  localparam logic [IRW-1:0] RST_IR = 4'hF;
`endif

  localparam int TLR = 0, RTI = 1, SDR = 2, CDR = 3, SHD = 4, E1D = 5, PD = 6, E2D = 7,
                 UD = 8, SIR = 9, CIR = 10, SHI = 11, E1I = 12, PI = 13, E2I = 14, UI = 15;

  // Next state indexed by [state][TMS].
  int nx [16][2] = '{'{RTI, TLR}, '{RTI, SDR}, '{CDR, SIR}, '{SHD, E1D}, '{SHD, E1D},
                     '{PD, UD},   '{PD, E2D},  '{SHD, UD},  '{RTI, SDR}, '{CIR, TLR},
                     '{SHI, E1I}, '{SHI, E1I}, '{PI, UI},   '{PI, E2I},  '{SHI, UI},
                     '{RTI, SDR}};

  // TMS sequences that walk from Run-Test/Idle to each state, same order as above.
  string paths [16] = '{"111", "", "1", "10", "100", "101", "1010", "10101", "1011",
                        "11", "110", "1100", "1101", "11010", "110101", "11011"};

  logic           TCLK, TRESETN, TMS, TDI;
  logic           TDO, TDO_EN, CaptureDR, ShiftDR, UpdateDR;
  logic [NT-1:0]  TDR_EN, TDR_SO;
  logic [IRW-1:0] IR;

  jtag_tap_ctrl #(.IR_WIDTH(IRW), .NUM_TDR(NT), .IDCODE_VALUE(IDV)) dut (
    .TCLK(TCLK), .TRESETN(TRESETN), .TMS(TMS), .TDI(TDI), .TDO(TDO), .TDO_EN(TDO_EN),
    .CaptureDR(CaptureDR), .ShiftDR(ShiftDR), .UpdateDR(UpdateDR),
    .TDR_EN(TDR_EN), .TDR_SO(TDR_SO), .IR(IR)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  initial TCLK = 1'b0;
  always #5 TCLK = ~TCLK;

  initial TDR_SO = '0;
  always @(posedge TCLK) begin
    #2;
    TDR_SO = NT'($urandom);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_idc(input logic [IRW-1:0] ir);
`ifdef TAP_IDCODE_EN
    return ir == 4'hE;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [NT-1:0] en_of(input logic [IRW-1:0] ir);
    logic [NT-1:0] r = '0;
    for (int k = 0; k < NT; k++) if (int'(ir) == k) r[k] = 1'b1;
    return r;
  endfunction

  // Reference model
  int             m_st;
  logic [IRW-1:0] m_irsh, m_ir;
  logic           m_byp, m_tdo, m_tdoen;
  logic [31:0]    m_idc;

  always @(posedge TCLK or negedge TRESETN) begin
    if (!TRESETN) begin
      m_st = TLR; m_irsh = '0; m_byp = 1'b0; m_idc = IDV;
    end else begin
      if (m_st == CIR) m_irsh = 4'b0001;
      if (m_st == SHI) m_irsh = (m_irsh >> 1) | (TDI ? 4'b1000 : 4'b0000);
      if (m_st == CDR) begin m_byp = 1'b0; m_idc = IDV; end
      if (m_st == SHD) begin
        if (en_of(m_ir) == '0 && !is_idc(m_ir)) m_byp = TDI;
        if (is_idc(m_ir)) m_idc = (m_idc >> 1) | (TDI ? 32'h8000_0000 : 32'h0);
      end
      m_st = nx[m_st][TMS ? 1 : 0];
    end
  end

  always @(negedge TCLK or negedge TRESETN) begin
    logic [NT-1:0] so;
    if (!TRESETN) begin
      m_ir = RST_IR; m_tdo = 1'b0; m_tdoen = 1'b0;
    end else begin
      m_tdoen = (m_st == SHI) || (m_st == SHD);
      m_tdo   = 1'b0;
      so      = TDR_SO >> m_ir;
      if (m_st == SHI) m_tdo = m_irsh[0];
      if (m_st == SHD) m_tdo = (en_of(m_ir) != '0) ? so[0] : is_idc(m_ir) ? m_idc[0] : m_byp;
      if (m_st == UI)  m_ir = m_irsh;
      if (m_st == TLR) m_ir = RST_IR;
    end
  end

  always @(negedge TCLK) begin
    #1;
    if (chk_en) begin
      check("cyc_CaptureDR", CaptureDR, m_st == CDR);
      check("cyc_ShiftDR", ShiftDR, m_st == SHD);
      check("cyc_UpdateDR", UpdateDR, m_st == UD);
      check("cyc_TDO", TDO, m_tdo);
      check("cyc_TDO_EN", TDO_EN, m_tdoen);
      check("cyc_IR", IR, m_ir);
      check("cyc_TDR_EN", TDR_EN, en_of(m_ir));
    end
  end

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms; TDI = tdi;
    @(posedge TCLK);
    @(negedge TCLK);
    #2;
  endtask

  // From RTI: scan v into IR, stop after the Update-IR tick; cap holds TDO bits LSB first.
  task automatic ir_scan(input logic [3:0] v, output logic [3:0] cap);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    cap[0] = TDO;
    for (int i = 0; i < 4; i++) begin
      tick(i == 3, v[i]);
      if (i < 3) cap[i+1] = TDO;
    end
    tick(1, 0);
  endtask

  initial begin
    logic [3:0]  cap, b;
    logic [31:0] idbits;
    int nc, ns, nu, ne;
    TRESETN = 1'b0; TMS = 1'b1; TDI = 1'b0;
    repeat (3) @(negedge TCLK);
    #2;
    chk_en = 1;
    check("rst_IR", IR, RST_IR);
    check("rst_TDR_EN", TDR_EN, 0);
    check("rst_TDO", TDO, 0);
    check("rst_TDO_EN", TDO_EN, 0);
    check("rst_strobes", {CaptureDR, ShiftDR, UpdateDR}, 0);
    TRESETN = 1'b1;
    tick(0, 0);

    ir_scan(4'h2, cap);
    check("ir_capture_out", cap, 4'b0001);
    check("ir_update_IR", IR, 4'h2);
    check("ir_update_TDR_EN", TDR_EN, 4'b0100);
    tick(0, 0);

    nc = 0; ns = 0; nu = 0; ne = 0;
    for (int i = 0; i < 22; i++) begin
      if (i < 2 || i == 21)  tick(0, 0);
      else if (i < 19)       tick(0, 1'($urandom));
      else if (i == 19)      tick(1, 1'($urandom));
      else                   tick(1, 0);
      if (i == 0) tick(1, 0);
      nc += CaptureDR; ns += ShiftDR; nu += UpdateDR; ne += TDO_EN;
    end
    check("dr17_capture_cycles", nc, 1);
    check("dr17_shift_cycles", ns, 17);
    check("dr17_update_cycles", nu, 1);
    check("dr17_tdo_en_cycles", ne, 17);

    ir_scan(4'h5, cap);
    check("unused_op_TDR_EN", TDR_EN, 4'b0000);
    tick(0, 0);
    ir_scan(4'hF, cap);
    check("bypass_TDR_EN", TDR_EN, 4'b0000);
    tick(0, 0);
    tick(1, 0); tick(0, 0); tick(0, 0); b[0] = TDO;
    tick(0, 1); b[1] = TDO;
    tick(0, 0); b[2] = TDO;
    tick(0, 1); b[3] = TDO;
    tick(1, 1); tick(1, 0); tick(0, 0);
    check("bypass_tdo_seq", b, 4'b1010);

    ir_scan(4'h1, cap);
    tick(0, 0);
    tick(1, 0); tick(0, 0); tick(0, 0); tick(0, 1);
    check("pre_reset_ShiftDR", ShiftDR, 1);
    TRESETN = 1'b0;
    #1;
    check("abort_TDO", TDO, 0);
    check("abort_TDO_EN", TDO_EN, 0);
    check("abort_ShiftDR", ShiftDR, 0);
    check("abort_IR", IR, RST_IR);
    nu = 0;
    #1;
    repeat (2) begin tick(1, 0); nu += UpdateDR; end
    TRESETN = 1'b1;
    repeat (3) begin tick(1, 0); nu += UpdateDR; end
    check("abort_no_update", nu, 0);
    check("abort_TDR_EN", TDR_EN, 0);
    tick(0, 0);

    for (int s = 0; s < 16; s++) begin
      ir_scan(4'h2, cap);
      tick(0, 0);
      for (int i = 0; i < paths[s].len(); i++) tick(paths[s].getc(i) == 8'h31, 0);
      repeat (5) tick(1, 0);
      check($sformatf("tlr5_IR_from_%0d", s), IR, RST_IR);
      check($sformatf("tlr5_TDR_EN_from_%0d", s), TDR_EN, 0);
      tick(0, 0);
    end

`ifdef TAP_IDCODE_EN
    TRESETN = 1'b0;
    tick(1, 0);
    TRESETN = 1'b1;
    tick(0, 0);
    tick(1, 0); tick(0, 0); tick(0, 0);
    idbits[0] = TDO;
    for (int i = 1; i < 32; i++) begin tick(0, 0); idbits[i] = TDO; end
    tick(1, 0); tick(1, 0); tick(0, 0);
    check("idcode_first_bit", idbits[0], 1);
    check("idcode_value", idbits, 32'h1234_5679);
`endif

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
